// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL dual-rail XOR reduction block:
// FSM state encoding, precharge rail value and the rail-pair check.
package wddl_pkg;

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_IDLE = 2'd1,
    ST_EVAL = 2'd2
  } wddl_state_e;

  localparam logic WDDL_PRECHARGE = 1'b0;

  // A rail pair carries a valid logic value only when the two rails differ.
  function automatic logic rail_pair_ok(input logic t, input logic f);
    return t ^ f;
  endfunction

endpackage

// File: rtl/wddl_xor_tree.sv
// Combinational dual-rail XOR reduction of NUM_IN words, folded left to right.
// Each step only ANDs and ORs positive rails, so a 0/0 input yields a 0/0 output.
module wddl_xor_tree
  import wddl_pkg::*;
#(
  parameter int WORD   = 32,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WORD-1:0] in_t,
  input  logic [NUM_IN*WORD-1:0] in_f,
  output logic [WORD-1:0]        out_t,
  output logic [WORD-1:0]        out_f
);

  logic [WORD-1:0] acc_t_s [NUM_IN];
  logic [WORD-1:0] acc_f_s [NUM_IN];

  assign acc_t_s[0] = in_t[0 +: WORD];
  assign acc_f_s[0] = in_f[0 +: WORD];

  for (genvar k = 1; k < NUM_IN; k++) begin : g_fold
    logic [WORD-1:0] b_t_s;
    logic [WORD-1:0] b_f_s;
    assign b_t_s = in_t[k*WORD +: WORD];
    assign b_f_s = in_f[k*WORD +: WORD];
    assign acc_t_s[k] = (acc_t_s[k-1] & b_f_s) | (acc_f_s[k-1] & b_t_s);
    assign acc_f_s[k] = (acc_t_s[k-1] & b_t_s) | (acc_f_s[k-1] & b_f_s);
  end

  assign out_t = acc_t_s[NUM_IN-1];
  assign out_f = acc_f_s[NUM_IN-1];

endmodule

// File: rtl/wddl_xor_reduce_reg.sv
// Registered WDDL dual-rail XOR reduction with a precharge phase between evaluations.
// Optional feature macro: WDDL_ALARM_EN (sticky fault flag on non-complementary input rails).
module wddl_xor_reduce_reg
  import wddl_pkg::*;
#(
  parameter int WORD   = 32,
  parameter int NUM_IN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*WORD-1:0] in_t,
  input  logic [NUM_IN*WORD-1:0] in_f,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD-1:0]        out_t,
  output logic [WORD-1:0]        out_f
`ifdef WDDL_ALARM_EN
  ,
  output logic                   fault
`endif
);

  if (NUM_IN < 2) begin : g_bad_num_in
    $error("wddl_xor_reduce_reg: NUM_IN must be >= 2");
  end

  localparam logic [WORD-1:0] PRE_WORD = {WORD{WDDL_PRECHARGE}};

  wddl_state_e     state_r;
  wddl_state_e     state_nxt_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [WORD-1:0] out_t_r;
  logic [WORD-1:0] out_f_r;
  logic [WORD-1:0] out_t_nxt_s;
  logic [WORD-1:0] out_f_nxt_s;
  logic [WORD-1:0] tree_t_s;
  logic [WORD-1:0] tree_f_s;
  logic [WORD-1:0] load_t_s;
  logic [WORD-1:0] load_f_s;

  wddl_xor_tree #(
    .WORD  (WORD),
    .NUM_IN(NUM_IN)
  ) u_tree (
    .in_t (in_t),
    .in_f (in_f),
    .out_t(tree_t_s),
    .out_f(tree_f_s)
  );

`ifdef WDDL_ALARM_EN
  logic [NUM_IN*WORD-1:0] pair_ok_s;
  logic                   bad_pair_s;
  logic                   accept_s;
  logic                   fault_r;

  for (genvar i = 0; i < NUM_IN*WORD; i++) begin : g_pair_chk
    assign pair_ok_s[i] = rail_pair_ok(in_t[i], in_f[i]);
  end

  assign bad_pair_s = ~(&pair_ok_s);
  assign accept_s   = (state_r == ST_IDLE) && in_valid;
  // A malformed operand must not leak data, so its result is replaced by precharge.
  assign load_t_s   = bad_pair_s ? PRE_WORD : tree_t_s;
  assign load_f_s   = bad_pair_s ? PRE_WORD : tree_f_s;

  // Sticky fault flag, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (accept_s && bad_pair_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign fault = fault_r;
`else
  assign load_t_s = tree_t_s;
  assign load_f_s = tree_f_s;
`endif

  // Next-state and next output-rail values for the PRE -> IDLE -> EVAL loop.
  always_comb begin
    state_nxt_s = state_r;
    out_t_nxt_s = out_t_r;
    out_f_nxt_s = out_f_r;
    case (state_r)
      ST_PRE: begin
        state_nxt_s = ST_IDLE;
        out_t_nxt_s = PRE_WORD;
        out_f_nxt_s = PRE_WORD;
      end
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_EVAL;
          out_t_nxt_s = load_t_s;
          out_f_nxt_s = load_f_s;
        end else begin
          state_nxt_s = ST_IDLE;
          out_t_nxt_s = PRE_WORD;
          out_f_nxt_s = PRE_WORD;
        end
      end
      ST_EVAL: begin
        if (out_ready) begin
          state_nxt_s = ST_PRE;
          out_t_nxt_s = PRE_WORD;
          out_f_nxt_s = PRE_WORD;
        end else begin
          state_nxt_s = ST_EVAL;
        end
      end
      default: begin
        state_nxt_s = ST_PRE;
        out_t_nxt_s = PRE_WORD;
        out_f_nxt_s = PRE_WORD;
      end
    endcase
  end

  // State and registered outputs; handshake flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_PRE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_t_r     <= PRE_WORD;
      out_f_r     <= PRE_WORD;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_EVAL);
      out_t_r     <= out_t_nxt_s;
      out_f_r     <= out_f_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_t     = out_t_r;
  assign out_f     = out_f_r;

endmodule

// File: tb/tb_wddl_xor_reduce_reg.sv
// Self-checking bench for wddl_xor_reduce_reg: a 2-operand and a 4-operand instance,
// a transaction-level reference model compared every cycle, plus directed literal checks.
module tb_wddl_xor_reduce_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [63:0]  in_t_a = 64'd0, in_f_a = 64'd0;
  logic         in_ready_a, out_valid_a;
  logic [31:0]  out_t_a, out_f_a;

  logic         in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [127:0] in_t_b = 128'd0, in_f_b = 128'd0;
  logic         in_ready_b, out_valid_b;
  logic [31:0]  out_t_b, out_f_b;
`ifdef WDDL_ALARM_EN
  logic         fault_a, fault_b;
`endif

  wddl_xor_reduce_reg #(.WORD(32), .NUM_IN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_t(in_t_a), .in_f(in_f_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_t(out_t_a), .out_f(out_f_a)
`ifdef WDDL_ALARM_EN
    , .fault(fault_a)
`endif
  );

  wddl_xor_reduce_reg #(.WORD(32), .NUM_IN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_t(in_t_b), .in_f(in_f_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_t(out_t_b), .out_f(out_f_b)
`ifdef WDDL_ALARM_EN
    , .fault(fault_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Any rail pair that is not complementary (0/0 or 1/1) among the first n operands.
  function automatic bit model_bad(input logic [127:0] t, input logic [127:0] f, input int n);
    bit bad = 1'b0;
    for (int k = 0; k < n; k++)
      if (~(t[k*32 +: 32] ^ f[k*32 +: 32]) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  // Expected {true, false} result: plain XOR of the true rails, or 0/0 for precharged/faulty input.
  function automatic logic [63:0] model_result(input logic [127:0] t, input logic [127:0] f, input int n);
    logic [31:0] x = 32'd0;
    bit all_pre = 1'b1;
    for (int k = 0; k < n; k++) begin
      x ^= t[k*32 +: 32];
      if (t[k*32 +: 32] != 32'd0 || f[k*32 +: 32] != 32'd0) all_pre = 1'b0;
    end
    if (all_pre) return 64'd0;
`ifdef WDDL_ALARM_EN
    if (model_bad(t, f, n)) return 64'd0;
`endif
    return {x, ~x};
  endfunction

  logic ma_ready, ma_valid, ma_fault;
  logic [63:0] ma_res;
  logic mb_ready, mb_valid, mb_fault;
  logic [63:0] mb_res;

  // Model of instance a: holding a result, waiting one precharge cycle, or ready to accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_ready <= 1'b0; ma_valid <= 1'b0; ma_res <= 64'd0; ma_fault <= 1'b0;
    end else if (ma_valid) begin
      if (out_ready_a) begin ma_valid <= 1'b0; ma_res <= 64'd0; end
    end else if (ma_ready) begin
      if (in_valid_a) begin
        ma_res   <= model_result({64'd0, in_t_a}, {64'd0, in_f_a}, 2);
        ma_fault <= ma_fault | model_bad({64'd0, in_t_a}, {64'd0, in_f_a}, 2);
        ma_ready <= 1'b0; ma_valid <= 1'b1;
      end
    end else begin
      ma_ready <= 1'b1;
    end
  end

  // Model of instance b, same rules with four operands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_ready <= 1'b0; mb_valid <= 1'b0; mb_res <= 64'd0; mb_fault <= 1'b0;
    end else if (mb_valid) begin
      if (out_ready_b) begin mb_valid <= 1'b0; mb_res <= 64'd0; end
    end else if (mb_ready) begin
      if (in_valid_b) begin
        mb_res   <= model_result(in_t_b, in_f_b, 4);
        mb_fault <= mb_fault | model_bad(in_t_b, in_f_b, 4);
        mb_ready <= 1'b0; mb_valid <= 1'b1;
      end
    end else begin
      mb_ready <= 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      check("a_in_ready",  {63'd0, in_ready_a},  {63'd0, ma_ready});
      check("a_out_valid", {63'd0, out_valid_a}, {63'd0, ma_valid});
      check("a_out_t",     {32'd0, out_t_a},     {32'd0, ma_res[63:32]});
      check("a_out_f",     {32'd0, out_f_a},     {32'd0, ma_res[31:0]});
      check("b_in_ready",  {63'd0, in_ready_b},  {63'd0, mb_ready});
      check("b_out_valid", {63'd0, out_valid_b}, {63'd0, mb_valid});
      check("b_out_t",     {32'd0, out_t_b},     {32'd0, mb_res[63:32]});
      check("b_out_f",     {32'd0, out_f_b},     {32'd0, mb_res[31:0]});
`ifdef WDDL_ALARM_EN
      check("a_fault", {63'd0, fault_a}, {63'd0, ma_fault});
      check("b_fault", {63'd0, fault_b}, {63'd0, mb_fault});
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  localparam logic [63:0] T2_T = {32'h0F0F_0F0F, 32'hFFFF_0000};

  initial begin : stim
    int last;
    int npulse;
    repeat (2) tick();
    rst_n = 1'b1;
    checking = 1'b1;
    // Reset release: PRE first, then IDLE
    check("rst_in_ready0", {63'd0, in_ready_a}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("rst_out_t", {32'd0, out_t_a}, 64'd0);
    check("rst_out_f", {32'd0, out_f_a}, 64'd0);
    tick();
    check("rst_in_ready1", {63'd0, in_ready_a}, 64'd1);

    // Two-operand evaluation, then hold with out_ready low
    in_t_a = T2_T; in_f_a = ~T2_T; in_valid_a = 1'b1; out_ready_a = 1'b0;
    tick();
    check("t2_valid", {63'd0, out_valid_a}, 64'd1);
    check("t2_out_t", {32'd0, out_t_a}, {32'd0, 32'hF0F0_0F0F});
    check("t2_out_f", {32'd0, out_f_a}, {32'd0, 32'h0F0F_F0F0});
    in_t_a = 64'h1234_5678_9ABC_DEF0; in_f_a = ~in_t_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", {63'd0, out_valid_a}, 64'd1);
      check("t3_hold_t", {32'd0, out_t_a}, {32'd0, 32'hF0F0_0F0F});
      check("t3_hold_f", {32'd0, out_f_a}, {32'd0, 32'h0F0F_F0F0});
      check("t3_hold_ready", {63'd0, in_ready_a}, 64'd0);
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    tick();
    check("t3_pre_valid", {63'd0, out_valid_a}, 64'd0);
    check("t3_pre_t", {32'd0, out_t_a}, 64'd0);
    check("t3_pre_f", {32'd0, out_f_a}, 64'd0);
    check("t3_pre_ready", {63'd0, in_ready_a}, 64'd0);
    out_ready_a = 1'b0;
    tick();
    check("t3_idle_ready", {63'd0, in_ready_a}, 64'd1);

`ifdef WDDL_ALARM_EN
    check("t6_fault_clear", {63'd0, fault_a}, 64'd0);
    in_t_a = T2_T | 64'd1; in_f_a = ~T2_T | 64'd1; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    check("t6_valid", {63'd0, out_valid_a}, 64'd1);
    check("t6_out_t", {32'd0, out_t_a}, 64'd0);
    check("t6_out_f", {32'd0, out_f_a}, 64'd0);
    check("t6_fault", {63'd0, fault_a}, 64'd1);
    out_ready_a = 1'b1; tick(); out_ready_a = 1'b0; tick();
    in_t_a = T2_T; in_f_a = ~T2_T; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    check("t6_legal_t", {32'd0, out_t_a}, {32'd0, 32'hF0F0_0F0F});
    check("t6_legal_f", {32'd0, out_f_a}, {32'd0, 32'h0F0F_F0F0});
    check("t6_fault_sticky", {63'd0, fault_a}, 64'd1);
    out_ready_a = 1'b1; tick(); out_ready_a = 1'b0; tick();
`endif

    // All-precharged operands still complete a transaction with a 0/0 result
    in_t_a = 64'd0; in_f_a = 64'd0; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    check("pre_in_valid", {63'd0, out_valid_a}, 64'd1);
    check("pre_in_t", {32'd0, out_t_a}, 64'd0);
    check("pre_in_f", {32'd0, out_f_a}, 64'd0);
    out_ready_a = 1'b1; tick(); out_ready_a = 1'b0; tick();

    // Four operands back to back: one result every third cycle
    in_t_b = {32'd8, 32'd4, 32'd2, 32'd1}; in_f_b = ~in_t_b;
    in_valid_b = 1'b1; out_ready_b = 1'b1;
    last = -1; npulse = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (out_valid_b) begin
        check("t4_out_t", {32'd0, out_t_b}, {32'd0, 32'h0000_000F});
        check("t4_out_f", {32'd0, out_f_b}, {32'd0, 32'hFFFF_FFF0});
        if (last >= 0) check("t4_cadence", 64'(cyc - last), 64'd3);
        last = cyc;
        npulse++;
      end
    end
    check("t4_npulse", 64'(npulse), 64'd4);
    in_valid_b = 1'b0;
    tick();

    // Asynchronous reset in the middle of EVAL
    in_t_a = T2_T; in_f_a = ~T2_T; in_valid_a = 1'b1; out_ready_a = 1'b0;
    tick();
    in_valid_a = 1'b0;
    check("t5_eval_valid", {63'd0, out_valid_a}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {63'd0, out_valid_a}, 64'd0);
    check("t5_rst_t", {32'd0, out_t_a}, 64'd0);
    check("t5_rst_f", {32'd0, out_f_a}, 64'd0);
    check("t5_rst_ready", {63'd0, in_ready_a}, 64'd0);
    tick();
    rst_n = 1'b1;
    check("t5_rel_ready0", {63'd0, in_ready_a}, 64'd0);
    tick();
    check("t5_rel_ready1", {63'd0, in_ready_a}, 64'd1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
